// File: rtl/mem_port_arbiter_if.sv
// Unified memory bus between the arbiter (master) and the memory (slave):
// variable-latency req/ack handshake with registered address and write data.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data accesses, with a
// bus-timeout watchdog. Define MEMARB_FAIRNESS_EN to alternate on contention.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    mem_port_arbiter_if.master bus,
    output logic              bus_err
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t            r_state, w_state_next;
    logic              r_owner_d;
    logic [15:0]       r_cnt;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_bus_err;
    logic              w_grant, w_grant_d, w_ack, w_abort, w_prefer_i;

`ifdef MEMARB_FAIRNESS_EN
    logic r_last_d;

    // Remember who won the last grant so a contended IDLE hands fetch a turn.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_last_d <= 1'b0;
        else if (w_grant)
            r_last_d <= w_grant_d;
    end

    assign w_prefer_i = r_last_d;
`else
    assign w_prefer_i = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_d    = 1'b0;
        w_ack        = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (d_req || i_req) begin
                    w_grant      = 1'b1;
                    w_grant_d    = d_req && !(i_req && w_prefer_i);
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // An ack in the last allowed cycle still wins over the abort.
                if (bus.mem_ack) begin
                    w_ack        = 1'b1;
                    w_state_next = ST_DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner_d   <= 1'b0;
            r_cnt       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner_d  <= w_grant_d;
                r_mem_we   <= w_grant_d & d_we;
                r_mem_be   <= w_grant_d ? d_be : 4'b1111;
                r_mem_addr <= w_grant_d ? d_addr : i_addr;
                if (w_grant_d)
                    r_mem_wdata <= d_wdata;
            end

            if (r_state == ST_BUSY && !w_ack && !w_abort)
                r_cnt <= r_cnt + 16'd1;
            else
                r_cnt <= '0;

            if (w_ack && !r_mem_we) begin
                if (r_owner_d)
                    r_d_rdata <= bus.mem_rdata;
                else
                    r_i_rdata <= bus.mem_rdata;
            end

            if (w_abort) begin
                if (r_owner_d)
                    r_d_rdata <= '0;
                else
                    r_i_rdata <= '0;
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus.mem_req   = (r_state == ST_BUSY);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    assign i_valid = (r_state == ST_DONE) && !r_owner_d;
    assign d_valid = (r_state == ST_DONE) &&  r_owner_d;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_stall = i_req & ~i_valid;
    assign d_stall = d_req & ~d_valid;
    assign bus_err = r_bus_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: expected timing comes from the
// latency rules (grant, busy length, done, idle) applied per transaction.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_valid;
    logic [DW-1:0] i_rdata;
    logic          i_stall;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [3:0]    d_be = 4'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          d_stall;
    logic          bus_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what each requester's rdata, the error flag and the
    // last granted owner should be, updated at transaction granularity.
    logic [DW-1:0] m_i_rdata = '0;
    logic [DW-1:0] m_d_rdata = '0;
    bit            m_bus_err = 1'b0;
    bit            m_last_d  = 1'b0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_valid (i_valid),
        .i_rdata (i_rdata),
        .i_stall (i_stall),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_be    (d_be),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_valid (d_valid),
        .d_rdata (d_rdata),
        .d_stall (d_stall),
        .bus     (bus),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One arbitration round: optional fetch and/or data request raised together,
    // each served once. Waits/timeouts/read data are given per requester.
    task automatic run_txn(input bit do_i, input bit do_d, input bit we, input logic [3:0] be,
                           input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] ia,
                           input int w_i, input int w_d, input bit to_i, input bit to_d,
                           input logic [31:0] rd_i, input logic [31:0] rd_d, input bit spur);
        bit          two, first_d;
        bit          own_d [2];
        int          l [2];
        bit          tmo [2];
        logic [31:0] rdv [2];
        int          s, v1, v2, last, ev, k;
        bit          in1, in2, eiv, edv;

        two     = do_i && do_d;
        first_d = do_d;
`ifdef MEMARB_FAIRNESS_EN
        if (two && m_last_d)
            first_d = 1'b0;
`endif
        own_d[0] = first_d;
        own_d[1] = !first_d;
        m_last_d = two ? !first_d : first_d;
        for (int j = 0; j < 2; j++) begin
            tmo[j] = own_d[j] ? to_d : to_i;
            l[j]   = tmo[j] ? TO : ((own_d[j] ? w_d : w_i) + 1);
            rdv[j] = own_d[j] ? rd_d : rd_i;
        end
        v1   = l[0] + 1;
        s    = l[0] + 2;
        v2   = two ? s + l[1] + 1 : v1;
        last = v2;

        @(negedge clk);
        check("idle_mem_req", bus.mem_req, 1'b0);
        check("idle_valid", {i_valid, d_valid}, 2'b00);
        bus.mem_ack   = spur;
        bus.mem_rdata = $urandom;
        i_req = do_i; i_addr = ia;
        d_req = do_d; d_we = we; d_be = be; d_addr = da; d_wdata = dwd;

        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            in1 = (n <= l[0]);
            in2 = two && (n >= s + 1) && (n <= s + l[1]);
            ev  = (n == v1) ? 0 : ((two && n == v2) ? 1 : -1);
            eiv = (ev >= 0) && !own_d[ev];
            edv = (ev >= 0) &&  own_d[ev];
            if (ev >= 0) begin
                if (tmo[ev]) begin
                    m_bus_err = 1'b1;
                    if (own_d[ev]) m_d_rdata = '0; else m_i_rdata = '0;
                end else if (!own_d[ev]) begin
                    m_i_rdata = rdv[ev];
                end else if (!we) begin
                    m_d_rdata = rdv[ev];
                end
            end
            check("mem_req", bus.mem_req, in1 || in2);
            check("i_valid", i_valid, eiv);
            check("d_valid", d_valid, edv);
            check("i_stall", i_stall, i_req & !eiv);
            check("d_stall", d_stall, d_req & !edv);
            check("bus_err", bus_err, m_bus_err);
            if (in1 || in2) begin
                k = in1 ? 0 : 1;
                check("mem_addr", bus.mem_addr, own_d[k] ? da : ia);
                check("mem_we", bus.mem_we, own_d[k] ? we : 1'b0);
                check("mem_be", bus.mem_be, own_d[k] ? be : 4'b1111);
                if (own_d[k] && we)
                    check("mem_wdata", bus.mem_wdata, dwd);
            end
            if (ev >= 0) begin
                check("i_rdata", i_rdata, m_i_rdata);
                check("d_rdata", d_rdata, m_d_rdata);
                if (own_d[ev]) d_req = 1'b0; else i_req = 1'b0;
            end
            if (n == l[0] && !tmo[0]) begin
                bus.mem_ack = 1'b1; bus.mem_rdata = rdv[0];
            end else if (two && n == s + l[1] && !tmo[1]) begin
                bus.mem_ack = 1'b1; bus.mem_rdata = rdv[1];
            end else begin
                bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        int          sel;
        bit          rw, ti, td;
        logic [3:0]  rbe;

        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_valid", {i_valid, d_valid}, 2'b00);
        check("rst_rdata", {i_rdata, d_rdata}, 64'h0);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_mem_bus", {bus.mem_we, bus.mem_be, bus.mem_addr}, '0);
        rst_n = 1'b1;

        // Zero-wait fetch, contended read with two waits, SB store, timeout.
        run_txn(1, 0, 0, 4'hf, 32'h0, 32'h0, 32'h0040_0000, 0, 0, 0, 0, 32'h2402_0005, 32'h0, 0);
        run_txn(1, 1, 0, 4'hf, 32'h1001_0000, 32'h0, 32'h0040_0004, 0, 2, 0, 0, 32'h1111_2222, 32'h3333_4444, 0);
        run_txn(0, 1, 1, 4'b0100, 32'h1001_0002, 32'h0000_AB00, 32'h0, 0, 1, 0, 0, 32'h0, 32'hDEAD_BEEF, 1);
        run_txn(0, 1, 0, 4'hf, 32'h1001_0008, 32'h0, 32'h0, 0, 0, 0, 1, 32'h0, 32'h5555_5555, 0);
        run_txn(1, 1, 0, 4'hf, 32'h1001_000C, 32'h0, 32'h0040_0008, 1, 0, 0, 0, 32'hA5A5_0001, 32'h5A5A_0002, 0);

        for (int it = 0; it < 150; it++) begin
            sel = $urandom_range(0, 2);
            rw  = $urandom_range(0, 1);
            rbe = rw ? (($urandom_range(0, 1) == 1) ? 4'hf : 4'(1 << $urandom_range(0, 3))) : 4'hf;
            ti  = ($urandom_range(0, 9) == 0);
            td  = !rw && ($urandom_range(0, 9) == 0);
            run_txn(sel != 1, sel != 0, rw, rbe, $urandom, $urandom, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2), ti, td,
                    $urandom, $urandom, $urandom_range(0, 3) == 0);
        end

        // Reset during BUSY, then a late ack must not complete anything.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hf; d_addr = 32'h1001_0010;
        @(negedge clk);
        check("rstmid_busy", bus.mem_req, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_i_rdata = '0; m_d_rdata = '0; m_bus_err = 1'b0; m_last_d = 1'b0;
        check("rstmid_mem_req", bus.mem_req, 1'b0);
        check("rstmid_rdata", {i_rdata, d_rdata}, 64'h0);
        check("rstmid_bus_err", bus_err, 1'b0);
        @(negedge clk);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("late_ack_valid", {i_valid, d_valid}, 2'b00);
        check("late_ack_req", bus.mem_req, 1'b0);
        check("late_ack_rdata", d_rdata, m_d_rdata);

        run_txn(1, 1, 0, 4'hf, 32'h1001_0020, 32'h0, 32'h0040_0010, 0, 0, 0, 0, 32'h0BAD_0001, 32'h0BAD_0002, 0);
        run_txn(1, 1, 0, 4'hf, 32'h1001_0024, 32'h0, 32'h0040_0014, 1, 1, 0, 0, 32'h0BAD_0003, 32'h0BAD_0004, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (LW/SW/SB data accesses).
- Grants one requester at a time and drives a variable-latency req/ack memory bus.
- Returns read data with a one-cycle valid pulse and produces per-requester stall signals for the hazard logic.
- Adds a bus-timeout watchdog that keeps a dead memory from hanging the pipeline.

Parameters:
- ADDR_W, 32, width of the byte address on all address ports.
- DATA_W, 32, width of the data word.
- TIMEOUT, 255, cycles in BUSY without mem_ack before the transaction is aborted (1..65535).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- i_req  in  1  fetch read request; held with i_addr until i_valid
- i_addr  in  ADDR_W  fetch address
- i_valid  out  1  one-cycle pulse; i_rdata valid
- i_rdata  out  DATA_W  fetched instruction word
- i_stall  out  1  i_req & ~i_valid
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_valid
- d_we  in  1  1 = write (SW/SB), 0 = read (LW)
- d_be  in  4  byte enables (4'b1111 word, one-hot for SB)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_valid  out  1  one-cycle completion pulse (reads and writes)
- d_rdata  out  DATA_W  load data
- d_stall  out  1  d_req & ~d_valid
- mem_req  out  1  held high until mem_ack
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables (4'b1111 for fetch)
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered store data
- mem_ack  in  1  one-cycle completion from memory; mem_rdata valid same cycle
- mem_rdata  in  DATA_W  read data
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset:
  - All outputs 0; state IDLE; timeout counter 0; bus_err 0.
  - Reset mid-transaction drops mem_req on the next edge.
  - A late mem_ack is ignored.
- State IDLE:
  - d_req=1: latch d_* into mem_* registers, owner=D, go BUSY.
  - Else i_req=1: latch i_addr, mem_we=0, mem_be=4'b1111, owner=I, go BUSY.
  - Data has fixed priority over fetch.
  - mem_req rises the cycle after the grant edge.
- State BUSY:
  - mem_req=1; all mem_* outputs held stable.
  - Counter increments each cycle.
  - mem_ack=1: on a read, capture mem_rdata into the owner's rdata register. Go DONE; counter cleared; mem_req=0 next cycle.
  - Counter reaches TIMEOUT with no ack: abort. Owner rdata = 32'h0000_0000; set bus_err; go DONE.
- State DONE:
  - Owner's valid = 1 for exactly this cycle; always go to IDLE next.
  - No grant is made from DONE, so a requester still holding req this cycle is never re-granted.
- Minimum latency (zero-wait memory):
  - Cycle t: req seen.
  - t+1: mem_req and mem_ack.
  - t+2: valid.
  - t+3: IDLE; next grant possible.
  - Each extra memory wait state adds one cycle.
- rdata persistence: i_rdata/d_rdata keep their last value until the next read completes for that requester. Writes leave d_rdata unchanged.
- Spurious input: mem_ack outside BUSY is ignored.
- Requester misbehaviour: a req dropped while granted does not cancel the bus transaction. It completes, and valid still pulses.
- bus_err: sticky until reset.

Optional Feature:
- MEMARB_FAIRNESS_EN
- Defined: a 1-bit last-owner register is added. When both d_req and i_req are high in IDLE, and the previous grant was D, I is granted. Otherwise D keeps priority.
- Undefined: strict data priority as above; no extra state.

Test Plan:
- Zero-wait read: i_req=1, i_addr=0x0040_0000, mem_ack the same cycle mem_req rises with mem_rdata=0x2402_0005 -> i_valid pulses at t+2, i_rdata=0x2402_0005, i_stall high t..t+1.
- Simultaneous requests: i_req and d_req (read, 0x1001_0000) at t, 2 memory wait states -> data served first, d_valid at t+4; fetch then granted at t+5 (IDLE); mem_addr changes only at that grant.
- SB store: d_we=1, d_be=4'b0100, d_wdata=0x0000_AB00 -> mem_we=1, mem_be=4'b0100 held until ack; d_valid pulses; d_rdata unchanged.
- Timeout: TIMEOUT=4, no mem_ack -> abort after 4 BUSY cycles; d_valid with d_rdata=0; bus_err=1 and stays high.
- Reset mid-BUSY: rst_n=0 for one cycle during BUSY -> mem_req=0 after the edge; a mem_ack 2 cycles later produces no valid.
- Fairness (with MEMARB_FAIRNESS_EN): d_req and i_req held continuously -> grants alternate D, I, D. Without the macro, D is always granted.
